// File: rtl/ascon_pack.sv
// Shared types and helpers for the iterative ASCON permutation engine.
package ascon_pack;

    // x0 lives in word [0], x4 in word [4]
    typedef logic [4:0][63:0] type_state;

    localparam logic [3:0] ROUND_MAX = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } perm_state_e;

    function automatic logic [7:0] round_constant(input logic [3:0] r);
        return {4'hf - r, r};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant_add -> substitution_layer -> diffusion_layer.
module ascon_round
    import ascon_pack::*;
(
    input  type_state   S_i,
    input  logic [3:0]  round_i,
    output type_state   S_o
);

    type_state c_st;
    type_state s_st;

    always_comb begin : constant_add
        c_st    = S_i;
        c_st[2] = S_i[2] ^ {56'd0, round_constant(round_i)};
    end

    always_comb begin : substitution_layer
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = c_st[0] ^ c_st[4];
        x4 = c_st[4] ^ c_st[3];
        x2 = c_st[2] ^ c_st[1];
        x1 = c_st[1];
        x3 = c_st[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        s_st[1] = x1 ^ x0;
        s_st[0] = x0 ^ x4;
        s_st[3] = x3 ^ x2;
        s_st[2] = ~x2;
        s_st[4] = x4;
    end

    always_comb begin : diffusion_layer
        S_o[0] = s_st[0] ^ ror64(s_st[0], 19) ^ ror64(s_st[0], 28);
        S_o[1] = s_st[1] ^ ror64(s_st[1], 61) ^ ror64(s_st[1], 39);
        S_o[2] = s_st[2] ^ ror64(s_st[2],  1) ^ ror64(s_st[2],  6);
        S_o[3] = s_st[3] ^ ror64(s_st[3], 10) ^ ror64(s_st[3], 17);
        S_o[4] = s_st[4] ^ ror64(s_st[4],  7) ^ ror64(s_st[4], 41);
    end

endmodule

// File: rtl/ascon_perm_sequencer.sv
// Iterative ASCON permutation: one round per clock, p^A or p^B on request,
// result held until acknowledged.
module ascon_perm_sequencer
    import ascon_pack::*;
#(
    parameter int unsigned NB_ROUNDS_A = 12,
    parameter int unsigned NB_ROUNDS_B = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        mode_i,
    input  type_state   state_i,
    output logic        ready_o,
    output logic        valid_o,
    input  logic        ack_i,
    output type_state   state_o,
    output logic [3:0]  round_o
);

    localparam logic [3:0] FIRST_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] FIRST_B = 4'(12 - NB_ROUNDS_B);

    perm_state_e fsm_q, fsm_d;
    type_state   st_q, st_d;
    logic [3:0]  cnt_q, cnt_d;
    type_state   round_out;

    ascon_round u_round (
        .S_i     (st_q),
        .round_i (cnt_q),
        .S_o     (round_out)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q <= ST_IDLE;
            st_q  <= '0;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    st_d  = state_i;
                    cnt_d = mode_i ? FIRST_B : FIRST_A;
                    fsm_d = ST_RUN;
                end
            end
            ST_RUN: begin
                st_d = round_out;
                if (cnt_q == ROUND_MAX) begin
                    fsm_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                valid_o = 1'b1;
                // start_i deliberately ignored here; a new request needs an IDLE cycle
                if (ack_i) begin
                    fsm_d = ST_IDLE;
                    cnt_d = '0;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign state_o = st_q;
    assign round_o = cnt_q;

endmodule
